// File: rtl/fetch_sequencer_pkg.sv
// Shared CPU control definitions: fetch sequencer state encodings.
package fetch_sequencer_pkg;

    localparam int FETCH_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: sequences the ProgramCounter, fetches words
// from the instruction bus and presents them to decode over valid/ready.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = FETCH_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] pcValue,
    output logic [DATA_WIDTH-1:0] pcDataIn,
    output logic                  pcWriteEnable,
    output logic                  pcWriteAdd,
    output logic                  pcCountEnable,
    output logic                  memRequest,
    output logic [DATA_WIDTH-1:0] memAddress,
    input  logic                  memReady,
    input  logic [DATA_WIDTH-1:0] memData,
    output logic                  instrValid,
    output logic [DATA_WIDTH-1:0] instrData,
    output logic [DATA_WIDTH-1:0] instrAddress,
    input  logic                  instrReady,
    input  logic                  redirectValid,
    input  logic                  redirectRelative,
    input  logic [DATA_WIDTH-1:0] redirectTarget
);

    fetch_state_t          r_state;
    logic [DATA_WIDTH-1:0] r_instrData;
    logic [DATA_WIDTH-1:0] r_instrAddress;
    logic [DATA_WIDTH-1:0] r_redirTarget;
    logic                  r_redirRelative;

    logic                  w_apply;
    logic                  w_applyRelative;
    logic [DATA_WIDTH-1:0] w_applyTarget;
    logic                  w_count;

    // A live redirect always overrides the stored one, so the newest wins in DRAIN.
    always_comb begin
        w_apply         = 1'b0;
        w_applyRelative = redirectRelative;
        w_applyTarget   = redirectTarget;
        w_count         = 1'b0;
        case (r_state)
            FETCH: begin
                if (redirectValid && memReady) begin
                    w_apply = 1'b1;
                end
            end
            DRAIN: begin
                if (memReady) begin
                    w_apply = 1'b1;
                    if (!redirectValid) begin
                        w_applyRelative = r_redirRelative;
                        w_applyTarget   = r_redirTarget;
                    end
                end
            end
            HOLD: begin
                if (redirectValid) begin
                    w_apply = 1'b1;
                end else if (instrReady) begin
                    w_count = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        pcWriteEnable = !reset && w_apply;
        pcWriteAdd    = !reset && w_apply && w_applyRelative;
        pcDataIn      = (!reset && w_apply) ? w_applyTarget : '0;
        pcCountEnable = !reset && w_count;
        memRequest    = !reset && ((r_state == FETCH) || (r_state == DRAIN));
        memAddress    = reset ? '0 : pcValue;
        instrValid    = !reset && (r_state == HOLD);
        instrData     = reset ? '0 : r_instrData;
        instrAddress  = reset ? '0 : r_instrAddress;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= FETCH;
            r_instrData     <= '0;
            r_instrAddress  <= '0;
            r_redirTarget   <= '0;
            r_redirRelative <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (redirectValid && !memReady) begin
                        r_redirTarget   <= redirectTarget;
                        r_redirRelative <= redirectRelative;
                        r_state         <= DRAIN;
                    end else if (memReady && !redirectValid) begin
                        r_instrData    <= memData;
                        r_instrAddress <= pcValue;
                        r_state        <= HOLD;
                    end
                end
                DRAIN: begin
                    if (memReady) begin
                        r_state <= FETCH;
                    end else if (redirectValid) begin
                        r_redirTarget   <= redirectTarget;
                        r_redirRelative <= redirectRelative;
                    end
                end
                HOLD: begin
                    if (redirectValid || instrReady) begin
                        r_state <= FETCH;
                    end
                end
                default: r_state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: behavioural ProgramCounter and instruction memory,
// expected-instruction scoreboard, and directed cycle-level checks.
module tb_fetch_sequencer;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] data;
        logic [W-1:0] addr;
    } instr_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] pcValue;
    logic [W-1:0] pcDataIn;
    logic         pcWriteEnable;
    logic         pcWriteAdd;
    logic         pcCountEnable;
    logic         memRequest;
    logic [W-1:0] memAddress;
    logic         memReady;
    logic [W-1:0] memData;
    logic         instrValid;
    logic [W-1:0] instrData;
    logic [W-1:0] instrAddress;
    logic         instrReady;
    logic         redirectValid;
    logic         redirectRelative;
    logic [W-1:0] redirectTarget;

    logic         use_const;
    logic [W-1:0] pc_model;
    int           checks = 0;
    int           errors = 0;
    instr_t       exp_q[$];

    always #5 clk = ~clk;

    fetch_sequencer #(.DATA_WIDTH(W)) dut (
        .clk              (clk),
        .reset            (reset),
        .pcValue          (pcValue),
        .pcDataIn         (pcDataIn),
        .pcWriteEnable    (pcWriteEnable),
        .pcWriteAdd       (pcWriteAdd),
        .pcCountEnable    (pcCountEnable),
        .memRequest       (memRequest),
        .memAddress       (memAddress),
        .memReady         (memReady),
        .memData          (memData),
        .instrValid       (instrValid),
        .instrData        (instrData),
        .instrAddress     (instrAddress),
        .instrReady       (instrReady),
        .redirectValid    (redirectValid),
        .redirectRelative (redirectRelative),
        .redirectTarget   (redirectTarget)
    );

    function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
        return a ^ 32'hCAFE_0000;
    endfunction

    assign memData = !memReady ? 32'hBAD0_BAD0 :
                     (use_const ? 32'h0000_0013 : mem_word(memAddress));
    assign pcValue = pc_model;

    // ProgramCounter stand-in living beside the sequencer.
    always @(posedge clk) begin
        if (reset) pc_model <= '0;
        else if (pcWriteEnable) pc_model <= pcWriteAdd ? pc_model + pcDataIn : pcDataIn;
        else if (pcCountEnable) pc_model <= pc_model + 32'd4;
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: each presentation ends on accept or redirect.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (pcWriteEnable || pcCountEnable)
                chk("pc_ctrl_exclusive", {31'd0, pcWriteEnable && pcCountEnable}, 32'd0);
            if (instrValid && (instrReady || redirectValid)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr: got data 0x%08h addr 0x%08h, none expected", instrData, instrAddress);
                end else begin
                    instr_t e;
                    e = exp_q.pop_front();
                    chk("sb_instr_data", instrData, e.data);
                    chk("sb_instr_addr", instrAddress, e.addr);
                end
            end
        end
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        memReady = 1'b0;
        instrReady = 1'b0;
        redirectValid = 1'b0;
        redirectRelative = 1'b0;
        redirectTarget = '0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        memReady = 1'b1;
        instrReady = 1'b0;
        redirectValid = 1'b0;
        redirectRelative = 1'b0;
        redirectTarget = '0;
        use_const = 1'b0;

        // Reset held two cycles with memReady high.
        @(negedge clk);
        chk("rst_memRequest", {31'd0, memRequest}, 32'd0);
        chk("rst_instrValid", {31'd0, instrValid}, 32'd0);
        chk("rst_instrData", instrData, 32'd0);
        chk("rst_instrAddress", instrAddress, 32'd0);
        chk("rst_memAddress", memAddress, 32'd0);
        chk("rst_pcWriteEnable", {31'd0, pcWriteEnable}, 32'd0);
        chk("rst_pcCountEnable", {31'd0, pcCountEnable}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("rst2_memRequest", {31'd0, memRequest}, 32'd0);
        next_cycle();
        reset = 1'b0;
        exp_q.push_back('{data: mem_word(32'h0), addr: 32'h0});
        @(negedge clk);
        chk("first_memRequest", {31'd0, memRequest}, 32'd1);
        chk("first_memAddress", memAddress, 32'd0);
        next_cycle();
        memReady = 1'b0;
        @(negedge clk);
        chk("first_instrValid", {31'd0, instrValid}, 32'd1);
        chk("first_instrData", instrData, mem_word(32'h0));

        // Backpressure: five HOLD cycles without instrReady.
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_instrValid", {31'd0, instrValid}, 32'd1);
            chk("bp_instrData", instrData, mem_word(32'h0));
            chk("bp_pcCountEnable", {31'd0, pcCountEnable}, 32'd0);
            chk("bp_pc", pc_model, 32'd0);
            next_cycle();
        end
        instrReady = 1'b1;
        @(negedge clk);
        chk("bp_accept_count", {31'd0, pcCountEnable}, 32'd1);
        next_cycle();
        instrReady = 1'b0;
        @(negedge clk);
        chk("bp_after_valid", {31'd0, instrValid}, 32'd0);
        chk("bp_after_addr", memAddress, 32'd4);
        chk("bp_queue_empty", exp_q.size(), 32'd0);

        // Sequential fetch of constant words at 0,4,8,12.
        do_reset();
        memReady = 1'b1;
        instrReady = 1'b1;
        use_const = 1'b1;
        for (int k = 0; k < 4; k++)
            exp_q.push_back('{data: 32'h13, addr: 32'(k * 4)});
        for (int k = 0; k < 8; k++) begin
            if (k == 7) memReady = 1'b0;
            @(negedge clk);
            if (k % 2 == 0) begin
                chk("seq_memRequest", {31'd0, memRequest}, 32'd1);
                chk("seq_memAddress", memAddress, 32'((k / 2) * 4));
                chk("seq_fetch_invalid", {31'd0, instrValid}, 32'd0);
            end else begin
                chk("seq_instrValid", {31'd0, instrValid}, 32'd1);
                chk("seq_count", {31'd0, pcCountEnable}, 32'd1);
            end
            next_cycle();
        end
        @(negedge clk);
        chk("seq_next_addr", memAddress, 32'd16);
        chk("seq_queue_empty", exp_q.size(), 32'd0);
        use_const = 1'b0;

        // Absolute redirect in HOLD coinciding with the handshake.
        do_reset();
        memReady = 1'b1;
        exp_q.push_back('{data: mem_word(32'h0), addr: 32'h0});
        @(negedge clk);
        chk("abs_memAddress", memAddress, 32'd0);
        next_cycle();
        memReady = 1'b0;
        instrReady = 1'b1;
        redirectValid = 1'b1;
        redirectRelative = 1'b0;
        redirectTarget = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("abs_we", {31'd0, pcWriteEnable}, 32'd1);
        chk("abs_add", {31'd0, pcWriteAdd}, 32'd0);
        chk("abs_dataIn", pcDataIn, 32'hDEAD_BEEF);
        chk("abs_no_count", {31'd0, pcCountEnable}, 32'd0);
        next_cycle();
        redirectValid = 1'b0;
        instrReady = 1'b0;
        @(negedge clk);
        chk("abs_dropped", {31'd0, instrValid}, 32'd0);
        chk("abs_memRequest", {31'd0, memRequest}, 32'd1);
        chk("abs_next_addr", memAddress, 32'hDEAD_BEEF);
        chk("abs_queue_empty", exp_q.size(), 32'd0);

        // Relative redirect during a pending fetch at 0xC, memReady late by 3.
        do_reset();
        memReady = 1'b1;
        instrReady = 1'b1;
        for (int k = 0; k < 3; k++)
            exp_q.push_back('{data: mem_word(32'(k * 4)), addr: 32'(k * 4)});
        repeat (5) next_cycle();
        memReady = 1'b0;
        next_cycle();
        redirectValid = 1'b1;
        redirectRelative = 1'b1;
        redirectTarget = 32'hFFFF_FFFC;
        @(negedge clk);
        chk("rel_pending_addr", memAddress, 32'h0000_000C);
        chk("rel_no_write_yet", {31'd0, pcWriteEnable}, 32'd0);
        next_cycle();
        redirectValid = 1'b0;
        redirectTarget = '0;
        @(negedge clk);
        chk("rel_drain_req", {31'd0, memRequest}, 32'd1);
        chk("rel_drain_addr", memAddress, 32'h0000_000C);
        chk("rel_drain_valid", {31'd0, instrValid}, 32'd0);
        chk("rel_drain_we", {31'd0, pcWriteEnable}, 32'd0);
        next_cycle();
        next_cycle();
        memReady = 1'b1;
        @(negedge clk);
        chk("rel_apply_we", {31'd0, pcWriteEnable}, 32'd1);
        chk("rel_apply_add", {31'd0, pcWriteAdd}, 32'd1);
        chk("rel_apply_data", pcDataIn, 32'hFFFF_FFFC);
        next_cycle();
        memReady = 1'b0;
        @(negedge clk);
        chk("rel_late_dropped", {31'd0, instrValid}, 32'd0);
        chk("rel_next_addr", memAddress, 32'h0000_0008);
        chk("rel_queue_empty", exp_q.size(), 32'd0);

        // Reset asserted in DRAIN loses the stored redirect.
        do_reset();
        redirectValid = 1'b1;
        redirectRelative = 1'b0;
        redirectTarget = 32'h0000_0100;
        next_cycle();
        redirectValid = 1'b0;
        next_cycle();
        reset = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("drst_memRequest", {31'd0, memRequest}, 32'd0);
        chk("drst_pcDataIn", pcDataIn, 32'd0);
        next_cycle();
        reset = 1'b0;
        memReady = 1'b1;
        exp_q.push_back('{data: mem_word(32'h0), addr: 32'h0});
        @(negedge clk);
        chk("drst_memAddress", memAddress, 32'd0);
        chk("drst_no_write", {31'd0, pcWriteEnable}, 32'd0);
        next_cycle();
        memReady = 1'b0;
        instrReady = 1'b1;
        @(negedge clk);
        chk("drst_instrValid", {31'd0, instrValid}, 32'd1);
        next_cycle();
        instrReady = 1'b0;
        @(negedge clk);
        chk("drst_next_addr", memAddress, 32'd4);

        // Newest redirect wins in DRAIN; redirect with memReady in FETCH.
        do_reset();
        redirectValid = 1'b1;
        redirectRelative = 1'b0;
        redirectTarget = 32'h0000_0100;
        next_cycle();
        redirectRelative = 1'b1;
        redirectTarget = 32'h0000_0020;
        next_cycle();
        redirectValid = 1'b0;
        redirectTarget = '0;
        memReady = 1'b1;
        @(negedge clk);
        chk("newest_we", {31'd0, pcWriteEnable}, 32'd1);
        chk("newest_add", {31'd0, pcWriteAdd}, 32'd1);
        chk("newest_data", pcDataIn, 32'h0000_0020);
        next_cycle();
        redirectValid = 1'b1;
        redirectRelative = 1'b0;
        redirectTarget = 32'h0000_0040;
        @(negedge clk);
        chk("fr_addr", memAddress, 32'h0000_0020);
        chk("fr_we", {31'd0, pcWriteEnable}, 32'd1);
        chk("fr_data", pcDataIn, 32'h0000_0040);
        next_cycle();
        redirectValid = 1'b0;
        memReady = 1'b0;
        @(negedge clk);
        chk("fr_discarded", {31'd0, instrValid}, 32'd0);
        chk("fr_next_addr", memAddress, 32'h0000_0040);
        chk("final_queue_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
